// File: rtl/vector_pkg.sv
// vector_pkg: opcodes, FSM state encoding and lane-slice helper shared by the vector unit
package vector_pkg;
  localparam logic [2:0] OP_VLD = 3'd0, OP_VST = 3'd1, OP_VADD = 3'd2, OP_VSUB = 3'd3, OP_VADDS = 3'd4, OP_VRED = 3'd5;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_STORE, S_EXEC, S_DONE} state_t;
  function automatic int lane_lsb(input int i, input int ew);
    return i * ew;
  endfunction
endpackage

// File: rtl/vector_regfile.sv
// vector_regfile: NVREG x (LANES*EW) register file, two async read ports + debug read, one sync write, async active-low clear
module vector_regfile import vector_pkg::*; #(
  parameter int NVREG = 4,
  parameter int LANES = 4,
  parameter int EW = 8,
  localparam int RW = $clog2(NVREG),
  localparam int VW = LANES * EW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [RW-1:0] wa,
  input  logic [VW-1:0] wd,
  input  logic [RW-1:0] ra1,
  input  logic [RW-1:0] ra2,
  input  logic [RW-1:0] dbg_sel,
  output logic [VW-1:0] rd1,
  output logic [VW-1:0] rd2,
  output logic [VW-1:0] dbg_vec
);
  logic [VW-1:0] regs [NVREG];
  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
  assign dbg_vec = regs[dbg_sel];
  always_ff @(posedge clock or negedge reset)
    if (!reset) for (int i = 0; i < NVREG; i++) regs[i] <= '0;
    else if (we) regs[wa] <= wd;
endmodule

// File: rtl/vector_unit.sv
// vector_unit: vector coprocessor (VLD/VST/VADD/VSUB/VADDS/VRED) with start/done handshake and sequential memory port
module vector_unit import vector_pkg::*; #(
  parameter int LANES = 4,
  parameter int EW = 8,
  parameter int AW = 8,
  parameter int NVREG = 4,
  localparam int RW = $clog2(NVREG),
  localparam int VW = LANES * EW,
  localparam int SW = (LANES - 1) * EW,
  localparam int KW = $clog2(LANES)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [RW-1:0] vd,
  input  logic [RW-1:0] vs1,
  input  logic [RW-1:0] vs2,
  input  logic [AW-1:0] base,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rden,
  output logic          mem_wren,
  output logic [EW-1:0] mem_wdata,
  input  logic [EW-1:0] mem_rdata,
  output logic [EW-1:0] scalar_out,
  output logic          n_flag,
  output logic          z_flag,
  input  logic [RW-1:0] dbg_sel,
  output logic [VW-1:0] dbg_vec
);
  state_t state;
  logic [2:0] op_q;
  logic [RW-1:0] vd_q, vs1_q, vs2_q, ra1;
  logic [KW-1:0] k;
  logic [SW-1:0] stage;
  logic [VW-1:0] rd1, rd2, res, wd;
  logic [EW-1:0] red;
  logic we, last;
  assign last = k == KW'(LANES - 1);
  assign ra1 = state == S_IDLE ? vs1 : vs1_q;
  assign we = state == S_DRAIN || (state == S_EXEC && (op_q == OP_VADD || op_q == OP_VSUB || op_q == OP_VADDS));
  assign wd = state == S_DRAIN ? {mem_rdata, stage} : res;
  vector_regfile #(.NVREG(NVREG), .LANES(LANES), .EW(EW)) u_vrf (
    .clock(clock), .reset(reset), .we(we), .wa(vd_q), .wd(wd),
    .ra1(ra1), .ra2(vs2_q), .dbg_sel(dbg_sel), .rd1(rd1), .rd2(rd2), .dbg_vec(dbg_vec)
  );
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [EW-1:0] a, b;
    logic [EW:0] s;
    assign a = rd1[lane_lsb(i, EW) +: EW];
    assign b = rd2[lane_lsb(i, EW) +: EW];
    assign s = {1'b0, a} + {1'b0, b};
    assign res[lane_lsb(i, EW) +: EW] = op_q == OP_VSUB ? a - b : op_q == OP_VADDS && s[EW] ? '1 : s[EW-1:0];
  end
  always_comb begin
    red = '0;
    for (int i = 0; i < LANES; i++) red = red + rd1[lane_lsb(i, EW) +: EW];
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      op_q <= '0;
      vd_q <= '0;
      vs1_q <= '0;
      vs2_q <= '0;
      k <= '0;
      stage <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      mem_addr <= '0;
      mem_rden <= 1'b0;
      mem_wren <= 1'b0;
      mem_wdata <= '0;
      scalar_out <= '0;
      n_flag <= 1'b0;
      z_flag <= 1'b0;
    end else
      case (state)
        S_IDLE:
          if (start) begin
            op_q <= op;
            vd_q <= vd;
            vs1_q <= vs1;
            vs2_q <= vs2;
            k <= '0;
            busy <= 1'b1;
            mem_addr <= base;
            mem_rden <= op == OP_VLD;
            mem_wren <= op == OP_VST;
            mem_wdata <= rd1[EW-1:0];
            state <= op == OP_VLD ? S_LOAD : op == OP_VST ? S_STORE : S_EXEC;
          end
        S_LOAD: begin
          if (k != '0) stage[lane_lsb(int'(k) - 1, EW) +: EW] <= mem_rdata;
          k <= k + KW'(1);
          mem_addr <= mem_addr + AW'(1);
          if (last) begin
            mem_rden <= 1'b0;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          done <= 1'b1;
          state <= S_DONE;
        end
        S_STORE: begin
          k <= k + KW'(1);
          mem_addr <= mem_addr + AW'(1);
          mem_wdata <= rd1[lane_lsb(int'(k) + 1, EW) +: EW];
          if (last) begin
            mem_wren <= 1'b0;
            done <= 1'b1;
            state <= S_DONE;
          end
        end
        S_EXEC: begin
          if (op_q == OP_VRED) begin
            scalar_out <= red;
            n_flag <= red[EW-1];
            z_flag <= red == '0;
          end
          err <= op_q > OP_VRED;
          done <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done <= 1'b0;
          err <= 1'b0;
          busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
endmodule

// File: doc/vector_unit.md
Name: vector_unit

Overview:
- Parametrised vector coprocessor.
- Owns a vector register file of NVREG registers, each holding LANES elements of EW bits.
- Executes one vector instruction per start/done handshake: load, store, lane-wise add/sub/saturating add, or sum-reduction to a scalar.
- Sits beside the scalar multicycle datapath and shares its single-port synchronous data memory through a sequential one-element-per-cycle memory port.

Parameters:
LANES, 4, elements per vector (>=2)
EW, 8, element and memory data width
AW, 8, memory address width
NVREG, 4, number of vector registers (power of 2); RW = log2(NVREG)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request; sampled only when busy=0
op  in  3  opcode: 0 VLD, 1 VST, 2 VADD, 3 VSUB, 4 VADDS, 5 VRED, 6-7 illegal
vd  in  RW  destination vector register
vs1  in  RW  source 1 (VST data, VRED source)
vs2  in  RW  source 2
base  in  AW  memory base address for VLD/VST
busy  out  1  instruction in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done for an illegal op
mem_addr  out  AW  memory address
mem_rden  out  1  memory read strobe
mem_wren  out  1  memory write enable
mem_wdata  out  EW  memory write data
mem_rdata  in  EW  read data, valid one cycle after mem_rden
scalar_out  out  EW  VRED result register
n_flag  out  1  MSB of last VRED result
z_flag  out  1  last VRED result == 0
dbg_sel  in  RW  debug register select
dbg_vec  out  LANES*EW  combinational read of vreg[dbg_sel]

Behaviour:
- Lane packing: lane i occupies bits [i*EW+EW-1 : i*EW]. Lane 0 maps to address base; lane i maps to base+i mod 2^AW (addresses wrap).
- Reset (reset=0, asynchronous):
  - All vregs, scalar_out, n_flag, z_flag = 0.
  - busy, done, err, mem_rden, mem_wren = 0; mem_addr, mem_wdata = 0.
  - State = IDLE.
  - Reset mid-instruction abandons it; no partial register write survives.
- States: IDLE, LOAD, DRAIN, STORE, EXEC, DONE.
- IDLE:
  - start=1 at edge t latches op, vd, vs1, vs2 and base; busy=1 from edge t.
  - start while busy=1 is ignored and is not queued.
- VLD path: LOAD, then DRAIN, then DONE.
  - LOAD lasts LANES cycles, index k=0..LANES-1: mem_rden=1, mem_addr=base+k.
  - mem_rdata is captured into a staging buffer lane k-1 in the following cycle.
  - DRAIN captures the last element; the full vector is written to vd at DRAIN's end edge.
  - vd is never partially updated.
  - done=1 after edge t+LANES+1; busy=0 after edge t+LANES+2.
- VST path: STORE (LANES cycles), then DONE.
  - Cycle k drives mem_wren=1, mem_addr=base+k, mem_wdata=vs1 lane k.
  - done=1 after edge t+LANES.
- VADD/VSUB/VADDS/VRED path: EXEC (1 cycle), then DONE; done=1 after edge t+1.
  - Sources are read combinationally in EXEC; the result is written at EXEC's end edge. vd may equal vs1 or vs2.
  - VADD/VSUB: per-lane arithmetic mod 2^EW. No carry crosses a lane.
  - VADDS: per-lane unsigned saturating add; clamps to 2^EW-1.
  - VRED: scalar_out = sum of vs1 lanes mod 2^EW. n_flag/z_flag update only on VRED. The VRF is unchanged.
- Illegal op (6, 7): DONE directly; done=err=1 after edge t+1. No state change.
- DONE: one cycle; done=1; returns to IDLE. A start in the IDLE cycle after DONE is accepted normally.
- mem_rden and mem_wren are 0 outside LOAD and STORE respectively; they are never both 1.

Decomposition:
- Package vector_pkg holds:
  - opcode localparams (VLD..VRED);
  - state encoding;
  - a lane-slice helper function.
- Sub-module vector_regfile(NVREG, LANES, EW):
  - two combinational read ports plus the debug read port;
  - one synchronous write port;
  - asynchronous active-low clear.
- Lane arithmetic is a generate loop inside vector_unit.

Test Plan:
1. Assert reset mid-operation, release -> busy=done=err=mem_wren=mem_rden=0, scalar_out=0, dbg_vec=0 for all four vregs.
2. VLD vd=1, base=0xFE, mem[FE..01]=11,22,33,44 -> mem_addr sequence FE,FF,00,01; v1=0x44332211; done after edge t+5.
3. v1=0x44332211 -> VADD vd=2,vs1=vs2=1 gives v2=0x88664422. VADDS on lanes F0+20 gives FF. VSUB lane 00-01 gives FF. Each has done after t+1.
4. VST vs1=2, base=0x10 -> mem_wren high 4 cycles, addr 10..13, wdata 22,44,66,88; done after t+4.
5. VRED vs1=0x80402010 -> scalar_out=F0, n=1, z=0. VRED vs1=0x01FF0000 -> scalar_out=00, z=1, n=0.
6. Busy, illegal-op and abort cases:
   - start pulsed while busy -> ignored.
   - op=7 -> done=err=1 after t+1.
   - reset asserted in the third LOAD cycle -> vd stays 0, busy=0 immediately.
